// File: rtl/css_mcu0_dmi_req_tracker.sv
// css_mcu0_dmi_req_tracker
//
// Converts synchronized one-cycle DMI read/write pulses from the MCU0 TAP into
// a single outstanding valid/ready request toward the Debug Module. It tracks
// the response and keeps the sticky DMI status that the TAP captures on its
// next DR scan. Only one request can be outstanding at a time. If no response
// arrives within TIMEOUT cycles of acceptance, the request is aborted.
//
// Ports
//   clk, rst             debug clock, synchronous active-high reset
//   dmi_wr_en/dmi_rd_en  request pulses from the TAP (addr/wdata valid with them)
//   dmi_reset            clears sticky status
//   dmi_hard_reset       aborts any in-flight request and clears status
//   rd_data              data of the last successful read
//   rd_status, dmi_stat  sticky status: 0 ok, 2 failed, 3 busy
//   idle                 constant run-test-idle hint
//   dm_req_*             request channel toward the DM (valid/ready)
//   dm_rsp_*             response pulse from the DM (always accepted)
//   dm_abort             one-cycle cancel of the in-flight DM transaction
//
// All outputs come straight from registers.

module css_mcu0_dmi_req_tracker #(
    parameter int AWIDTH    = 7,
    parameter int TIMEOUT   = 200,
    parameter int IDLE_HINT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmi_wr_en,
    input  logic              dmi_rd_en,
    input  logic [AWIDTH-1:0] dmi_addr,
    input  logic [31:0]       dmi_wdata,
    input  logic              dmi_reset,
    input  logic              dmi_hard_reset,
    output logic [31:0]       rd_data,
    output logic [1:0]        rd_status,
    output logic [1:0]        dmi_stat,
    output logic [2:0]        idle,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic              dm_req_write,
    output logic [AWIDTH-1:0] dm_req_addr,
    output logic [31:0]       dm_req_wdata,
    input  logic              dm_rsp_valid,
    input  logic [31:0]       dm_rsp_rdata,
    input  logic              dm_rsp_err,
    output logic              dm_abort
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam logic [1:0] STAT_OK   = 2'd0;
    localparam logic [1:0] STAT_FAIL = 2'd2;
    localparam logic [1:0] STAT_BUSY = 2'd3;

    // Counter is cleared on acceptance and counts every REQ/RSP cycle.
    // Reaching this value without a response ends the transaction.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [1:0]         stat_nxt, stat_base;
    logic [31:0]        rd_data_nxt;
    logic               valid_nxt, write_nxt, abort_nxt;
    logic [AWIDTH-1:0]  addr_nxt;
    logic [31:0]        wdata_nxt;
    logic               req_any, req_one, req_both, busy, cnt_expired;

    assign req_any     = dmi_wr_en | dmi_rd_en;
    assign req_one     = dmi_wr_en ^ dmi_rd_en;
    assign req_both    = dmi_wr_en & dmi_rd_en;
    assign busy        = (state != ST_IDLE);
    assign cnt_expired = (cnt == CNT_LAST);

    // dmi_reset clears first, so every other status event in the same
    // cycle is judged against the cleared value.
    assign stat_base   = dmi_reset ? STAT_OK : dmi_stat;

    assign rd_status   = dmi_stat;
    assign idle        = 3'(IDLE_HINT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        stat_nxt    = stat_base;
        rd_data_nxt = rd_data;
        valid_nxt   = dm_req_valid;
        write_nxt   = dm_req_write;
        addr_nxt    = dm_req_addr;
        wdata_nxt   = dm_req_wdata;
        abort_nxt   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_both) begin
                    // Reserved op: never forwarded.
                    if (stat_base == STAT_OK) stat_nxt = STAT_FAIL;
                end else if (req_one && stat_base == STAT_OK) begin
                    state_nxt = ST_REQ;
                    cnt_nxt   = 8'd0;
                    valid_nxt = 1'b1;
                    write_nxt = dmi_wr_en;
                    addr_nxt  = dmi_addr;
                    wdata_nxt = dmi_wdata;
                end
            end

            ST_REQ: begin
                cnt_nxt = cnt + 8'd1;
                // Only a response counts as completion, so an expiring
                // request is aborted even if ready arrives that cycle.
                if (cnt_expired) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                    abort_nxt = 1'b1;
                    if (stat_base == STAT_OK) stat_nxt = STAT_FAIL;
                end else if (dm_req_valid && dm_req_ready) begin
                    state_nxt = ST_RSP;
                    valid_nxt = 1'b0;
                end
            end

            ST_RSP: begin
                cnt_nxt = cnt + 8'd1;
                // A response in the expiring cycle beats the timeout.
                if (dm_rsp_valid) begin
                    state_nxt = ST_IDLE;
                    if (dm_rsp_err) begin
                        if (stat_base == STAT_OK) stat_nxt = STAT_FAIL;
                    end else if (!dm_req_write) begin
                        rd_data_nxt = dm_rsp_rdata;
                    end
                end else if (cnt_expired) begin
                    state_nxt = ST_IDLE;
                    abort_nxt = 1'b1;
                    if (stat_base == STAT_OK) stat_nxt = STAT_FAIL;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
            end
        endcase

        // A pulse that collides with an outstanding request is dropped. The
        // outcome of the outstanding request is applied first, so a failure
        // in the same cycle is the status that sticks.
        if (busy && req_any && stat_nxt == STAT_OK) stat_nxt = STAT_BUSY;

        // Hard reset wins over everything evaluated above, except rd_data
        // and the held request fields.
        if (dmi_hard_reset) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = 8'd0;
            stat_nxt    = STAT_OK;
            valid_nxt   = 1'b0;
            abort_nxt   = busy;
            rd_data_nxt = rd_data;
            write_nxt   = dm_req_write;
            addr_nxt    = dm_req_addr;
            wdata_nxt   = dm_req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 8'd0;
            dmi_stat     <= STAT_OK;
            rd_data      <= 32'd0;
            dm_req_valid <= 1'b0;
            dm_req_write <= 1'b0;
            dm_req_addr  <= '0;
            dm_req_wdata <= 32'd0;
            dm_abort     <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            dmi_stat     <= stat_nxt;
            rd_data      <= rd_data_nxt;
            dm_req_valid <= valid_nxt;
            dm_req_write <= write_nxt;
            dm_req_addr  <= addr_nxt;
            dm_req_wdata <= wdata_nxt;
            dm_abort     <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_css_mcu0_dmi_req_tracker.sv
// Bench for css_mcu0_dmi_req_tracker (TIMEOUT = 10).
// It runs a directed vector table, then hand-written multi-cycle sequences,
// then a randomized run. A transaction-level reference model is checked
// every cycle throughout.

module tb_css_mcu0_dmi_req_tracker;

    localparam int AW = 7;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          dmi_wr_en, dmi_rd_en, dmi_reset, dmi_hard_reset;
    logic [AW-1:0] dmi_addr;
    logic [31:0]   dmi_wdata;
    logic [31:0]   rd_data;
    logic [1:0]    rd_status, dmi_stat;
    logic [2:0]    idle;
    logic          dm_req_valid, dm_req_ready, dm_req_write;
    logic [AW-1:0] dm_req_addr;
    logic [31:0]   dm_req_wdata;
    logic          dm_rsp_valid, dm_rsp_err, dm_abort;
    logic [31:0]   dm_rsp_rdata;

    int checks = 0;
    int errors = 0;

    css_mcu0_dmi_req_tracker #(.AWIDTH(AW), .TIMEOUT(TO), .IDLE_HINT(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .dmi_wr_en      (dmi_wr_en),
        .dmi_rd_en      (dmi_rd_en),
        .dmi_addr       (dmi_addr),
        .dmi_wdata      (dmi_wdata),
        .dmi_reset      (dmi_reset),
        .dmi_hard_reset (dmi_hard_reset),
        .rd_data        (rd_data),
        .rd_status      (rd_status),
        .dmi_stat       (dmi_stat),
        .idle           (idle),
        .dm_req_valid   (dm_req_valid),
        .dm_req_ready   (dm_req_ready),
        .dm_req_write   (dm_req_write),
        .dm_req_addr    (dm_req_addr),
        .dm_req_wdata   (dm_req_wdata),
        .dm_rsp_valid   (dm_rsp_valid),
        .dm_rsp_rdata   (dm_rsp_rdata),
        .dm_rsp_err     (dm_rsp_err),
        .dm_abort       (dm_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction, tracked by the edge
    // index at which it was accepted.
    // ------------------------------------------------------------------
    bit          m_busy, m_acc, m_valid, m_wr, m_abort;
    logic [AW-1:0] m_addr;
    logic [31:0] m_wdata, m_rd;
    logic [1:0]  m_stat;
    int          m_edge = 0;
    int          m_t0   = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) begin
        logic [1:0] st;
        m_edge++;
        if (rst) begin
            m_busy = 0; m_acc = 0; m_valid = 0; m_wr = 0; m_abort = 0;
            m_addr = '0; m_wdata = '0; m_rd = '0; m_stat = 2'd0;
        end else if (dmi_hard_reset) begin
            m_abort = m_busy;
            m_busy  = 0;
            m_valid = 0;
            m_stat  = 2'd0;
        end else begin
            st      = dmi_reset ? 2'd0 : m_stat;
            m_abort = 0;
            if (m_busy) begin
                if (m_acc && dm_rsp_valid) begin
                    m_busy = 0;
                    if (dm_rsp_err) begin
                        if (st == 0) st = 2;
                    end else if (!m_wr) begin
                        m_rd = dm_rsp_rdata;
                    end
                end else if (m_edge - m_t0 == TO) begin
                    m_abort = 1; m_busy = 0; m_valid = 0;
                    if (st == 0) st = 2;
                end else if (!m_acc && dm_req_ready) begin
                    m_acc = 1; m_valid = 0;
                end
                if ((dmi_wr_en || dmi_rd_en) && st == 0) st = 3;
            end else if (dmi_wr_en && dmi_rd_en) begin
                if (st == 0) st = 2;
            end else if ((dmi_wr_en || dmi_rd_en) && st == 0) begin
                m_busy = 1; m_acc = 0; m_valid = 1; m_t0 = m_edge;
                m_wr = dmi_wr_en; m_addr = dmi_addr; m_wdata = dmi_wdata;
            end
            m_stat = st;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_valid",  32'(dm_req_valid), 32'(m_valid));
            chk("m_write",  32'(dm_req_write), 32'(m_wr));
            chk("m_addr",   32'(dm_req_addr),  32'(m_addr));
            chk("m_wdata",  dm_req_wdata,      m_wdata);
            chk("m_abort",  32'(dm_abort),     32'(m_abort));
            chk("m_stat",   32'(dmi_stat),     32'(m_stat));
            chk("m_rdstat", 32'(rd_status),    32'(m_stat));
            chk("m_rddata", rd_data,           m_rd);
            chk("m_idle",   32'(idle),         32'd1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clr_pulses();
        dmi_wr_en = 0; dmi_rd_en = 0; dmi_reset = 0; dmi_hard_reset = 0;
        dm_rsp_valid = 0; dm_rsp_err = 0;
    endtask

    // Advance one edge and land on the following negedge; pulses last one cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        clr_pulses();
    endtask

    typedef struct packed {
        logic          rd, wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          ready, rspv;
        logic [31:0]   rdata;
        logic          err, dres, hres;
        logic          e_valid;
        logic [1:0]    e_stat;
        logic [31:0]   e_rd;
        logic          e_abort;
    } vec_t;

    vec_t vt[14];

    initial begin
        clr_pulses();
        rst = 1; dmi_addr = '0; dmi_wdata = '0; dm_req_ready = 0; dm_rsp_rdata = '0;

        //           rd wr addr   wdata         rdy rspv rdata         err dres hres | valid stat rd_data      abort
        vt[0]  = '{1'b1,1'b0,7'h11,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b1,2'd0,32'h0,        1'b0};
        vt[1]  = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b0,2'd0,32'h0,        1'b0};
        vt[2]  = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b0,2'd0,32'h0,        1'b0};
        vt[3]  = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b1,32'hDEADBEEF, 1'b0,1'b0,1'b0, 1'b0,2'd0,32'hDEADBEEF, 1'b0};
        vt[4]  = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b0,2'd0,32'hDEADBEEF, 1'b0};
        vt[5]  = '{1'b0,1'b1,7'h22,32'h55,       1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b1,2'd0,32'hDEADBEEF, 1'b0};
        vt[6]  = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b0,2'd0,32'hDEADBEEF, 1'b0};
        vt[7]  = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b1,32'h77777777, 1'b1,1'b0,1'b0, 1'b0,2'd2,32'hDEADBEEF, 1'b0};
        vt[8]  = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0, 1'b0,2'd0,32'hDEADBEEF, 1'b0};
        vt[9]  = '{1'b1,1'b1,7'h05,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b0,2'd2,32'hDEADBEEF, 1'b0};
        vt[10] = '{1'b1,1'b0,7'h06,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b0,2'd2,32'hDEADBEEF, 1'b0};
        vt[11] = '{1'b1,1'b0,7'h33,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0, 1'b1,2'd0,32'hDEADBEEF, 1'b0};
        vt[12] = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0, 1'b0,2'd0,32'hDEADBEEF, 1'b0};
        vt[13] = '{1'b0,1'b0,7'h00,32'h0,        1'b1,1'b1,32'hCAFEF00D, 1'b0,1'b0,1'b0, 1'b0,2'd0,32'hCAFEF00D, 1'b0};

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(dm_req_valid), 32'd0);
        chk("rst_write", 32'(dm_req_write), 32'd0);
        chk("rst_addr",  32'(dm_req_addr),  32'd0);
        chk("rst_wdata", dm_req_wdata,      32'd0);
        chk("rst_abort", 32'(dm_abort),     32'd0);
        chk("rst_stat",  32'(dmi_stat),     32'd0);
        chk("rst_rd",    rd_data,           32'd0);
        chk("rst_idle",  32'(idle),         32'd1);
        rst = 0;
        mon_en = 1;

        // Directed table: read success, error response, reserved op, clear
        for (int i = 0; i < 14; i++) begin
            dmi_rd_en = vt[i].rd;  dmi_wr_en = vt[i].wr;
            dmi_addr  = vt[i].addr; dmi_wdata = vt[i].wdata;
            dm_req_ready = vt[i].ready; dm_rsp_valid = vt[i].rspv;
            dm_rsp_rdata = vt[i].rdata; dm_rsp_err = vt[i].err;
            dmi_reset = vt[i].dres; dmi_hard_reset = vt[i].hres;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(dm_req_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_stat",  i), 32'(dmi_stat),     32'(vt[i].e_stat));
            chk($sformatf("vec%0d_rd",    i), rd_data,           vt[i].e_rd);
            chk($sformatf("vec%0d_abort", i), 32'(dm_abort),     32'(vt[i].e_abort));
            if (i == 0) begin
                chk("rd_req_write", 32'(dm_req_write), 32'd0);
                chk("rd_req_addr",  32'(dm_req_addr),  32'h11);
            end
        end

        // Write with backpressure: request held for 5 stalled cycles
        dm_req_ready = 0; dmi_wr_en = 1; dmi_addr = 7'h05; dmi_wdata = 32'h12345678;
        tick();
        chk("bp_accept", 32'(dm_req_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(dm_req_valid), 32'd1);
            chk("bp_addr",  32'(dm_req_addr),  32'h05);
            chk("bp_wdata", dm_req_wdata,      32'h12345678);
            chk("bp_write", 32'(dm_req_write), 32'd1);
        end
        dm_req_ready = 1;
        tick();
        chk("bp_hs", 32'(dm_req_valid), 32'd0);
        dm_rsp_valid = 1; dm_rsp_rdata = 32'hFFFFFFFF;
        tick();
        chk("bp_rd_held", rd_data, 32'hCAFEF00D);
        chk("bp_stat", 32'(dmi_stat), 32'd0);

        // Busy: pulse in RSP, sticky until dmi_reset
        dmi_rd_en = 1; dmi_addr = 7'h11;
        tick(); tick();
        dmi_rd_en = 1;
        tick();
        chk("busy_stat", 32'(dmi_stat), 32'd3);
        dm_rsp_valid = 1; dm_rsp_rdata = 32'h0BADC0DE;
        tick();
        chk("busy_rsp_rd", rd_data, 32'h0BADC0DE);
        chk("busy_sticky", 32'(dmi_stat), 32'd3);
        dmi_rd_en = 1;
        tick();
        chk("busy_drop", 32'(dm_req_valid), 32'd0);
        dmi_reset = 1;
        tick();
        chk("busy_clear", 32'(dmi_stat), 32'd0);
        dmi_rd_en = 1; dmi_addr = 7'h12;
        tick();
        chk("busy_next_valid", 32'(dm_req_valid), 32'd1);
        chk("busy_next_addr",  32'(dm_req_addr),  32'h12);
        tick();
        dm_rsp_valid = 1; dm_rsp_rdata = 32'h11112222;
        tick();
        chk("busy_next_rd", rd_data, 32'h11112222);

        // Timeout: abort exactly TO cycles after acceptance
        dmi_rd_en = 1; dmi_addr = 7'h20;
        tick();
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("to_no_abort", 32'(dm_abort), 32'd0);
        end
        tick();
        chk("to_abort", 32'(dm_abort),     32'd1);
        chk("to_stat",  32'(dmi_stat),     32'd2);
        chk("to_valid", 32'(dm_req_valid), 32'd0);
        tick();
        chk("to_abort_once", 32'(dm_abort), 32'd0);
        dm_rsp_valid = 1; dm_rsp_rdata = 32'h99999999;
        tick();
        chk("to_late_rsp", rd_data, 32'h11112222);
        dmi_reset = 1;
        tick();

        // Hard reset mid-RSP together with a request pulse
        dmi_rd_en = 1; dmi_addr = 7'h30;
        tick(); tick();
        dmi_rd_en = 1;
        tick();
        chk("hr_pre_busy", 32'(dmi_stat), 32'd3);
        dmi_hard_reset = 1; dmi_rd_en = 1;
        tick();
        chk("hr_abort", 32'(dm_abort),     32'd1);
        chk("hr_stat",  32'(dmi_stat),     32'd0);
        chk("hr_valid", 32'(dm_req_valid), 32'd0);
        chk("hr_rd",    rd_data,           32'h11112222);
        tick();
        chk("hr_abort_once", 32'(dm_abort),     32'd0);
        chk("hr_no_req",     32'(dm_req_valid), 32'd0);

        // Reset mid-transaction: no abort pulse
        dmi_rd_en = 1;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rstmid_abort", 32'(dm_abort),     32'd0);
        chk("rstmid_valid", 32'(dm_req_valid), 32'd0);
        chk("rstmid_rd",    rd_data,           32'd0);

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            dmi_rd_en      = (r < 14) || (r >= 96);
            dmi_wr_en      = (r >= 14 && r < 28) || (r >= 96);
            dmi_addr       = AW'($urandom);
            dmi_wdata      = $urandom;
            dmi_reset      = ($urandom_range(0, 19) == 0);
            dmi_hard_reset = ($urandom_range(0, 59) == 0);
            dm_req_ready   = ($urandom_range(0, 9) < 7);
            dm_rsp_valid   = ($urandom_range(0, 9) < 3);
            dm_rsp_rdata   = $urandom;
            dm_rsp_err     = ($urandom_range(0, 4) == 0);
            rst            = ($urandom_range(0, 399) == 0);
            tick();
            rst = 0;
        end

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
